// File: rtl/stream_err_checker.sv
// In-order stream checker: FIFO of expected samples vs. actual DUT samples.
// STREAM_ERR_CHECKER_DISPLAY_EN enables per-mismatch simulation messages.
module stream_err_checker #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int TOL   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_exp_data,
  input  logic                     i_exp_valid,
  output logic                     o_exp_ready,
  input  logic [WIDTH-1:0]         i_act_data,
  input  logic                     i_act_valid,
  output logic                     o_act_ready,
  output logic                     o_err_pulse,
  output logic [CNT_W-1:0]         o_err_count,
  output logic [CNT_W-1:0]         o_match_count,
  output logic [CNT_W-1:0]         o_first_err_idx,
  output logic                     o_first_err_valid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);
  localparam logic [WIDTH:0] MOST_NEG = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] idx_cnt;
  logic [CNT_W-1:0] first_idx;
  logic             first_vld;
  logic             pulse;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign o_exp_ready = (level != FULL_LVL);
  assign o_act_ready = (level != '0);

  assign push = i_exp_valid && o_exp_ready && !i_clear;
  assign pop  = i_act_valid && o_act_ready && !i_clear;

  assign head = mem[rd_ptr];

  always_comb begin
    diff = {i_act_data[WIDTH-1], i_act_data}
         - {head[WIDTH-1], head};
    mag  = diff[WIDTH] ? -diff : diff;
    // -MOST_NEG overflows back to itself, so it must be rejected explicitly
    hit  = (diff != MOST_NEG) && (mag <= TOL_V);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse     <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
      idx_cnt   <= '0;
      first_idx <= '0;
      first_vld <= 1'b0;
    end else if (i_clear) begin
      pulse     <= 1'b0;
      err_cnt   <= '0;
      match_cnt <= '0;
      idx_cnt   <= '0;
      first_idx <= '0;
      first_vld <= 1'b0;
    end else begin
      pulse <= pop && !hit;
      if (pop) begin
        idx_cnt <= sat_inc(idx_cnt);
        if (hit) begin
          match_cnt <= sat_inc(match_cnt);
        end else begin
          err_cnt <= sat_inc(err_cnt);
          if (!first_vld) begin
            first_idx <= idx_cnt;
            first_vld <= 1'b1;
          end
        end
      end
    end
  end

  assign o_err_pulse       = pulse;
  assign o_err_count       = err_cnt;
  assign o_match_count     = match_cnt;
  assign o_first_err_idx   = first_idx;
  assign o_first_err_valid = first_vld;
  assign o_level           = level;

`ifdef STREAM_ERR_CHECKER_DISPLAY_EN
`ifndef SYNTHESIS
  // Fires on the edge that raises o_err_pulse, i.e. in the result cycle
  always @(posedge clk) begin
    if (rst_n && pop && !hit) begin
      $display("%0t stream_err_checker: idx=%0d act=%0d exp=%0d diff=%0d",
               $time, idx_cnt, $signed(i_act_data), $signed(head),
               $signed(diff));
    end
  end
`endif
`else
`endif

endmodule

// File: doc/stream_err_checker.md
# stream_err_checker

Synthesizable checker that produces the error events a simulation error tally consumes. It buffers an expected sample stream, such as CIC interpolator golden-model output, and compares each actual DUT sample in order against the oldest expected sample. It emits a one-cycle error pulse per mismatch and keeps saturating match/error counters plus the index of the first mismatch. It sits beside the DUT output in benches and can remain in hardware builds for on-target self-test.

## Interface
Parameters:
- WIDTH, 16: sample width; samples are signed two's complement.
- DEPTH, 16: expected-sample FIFO depth; must be a power of 2, ≥2.
- CNT_W, 32: width of the match counter, error counter and index counter.
- TOL, 0: maximum allowed |actual − expected|; unsigned, compared at WIDTH+1 bits.

Ports (`clk` is the single clock; `rst_n` is the reset, asynchronous assert, active-low):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of FIFO, counters and first-error capture.
- i_exp_data  in  WIDTH  expected sample.
- i_exp_valid  in  1  expected sample valid.
- o_exp_ready  out  1  FIFO can accept an expected sample.
- i_act_data  in  WIDTH  actual DUT sample.
- i_act_valid  in  1  actual sample valid.
- o_act_ready  out  1  checker can accept an actual sample.
- o_err_pulse  out  1  one-cycle pulse per mismatching sample.
- o_err_count  out  CNT_W  saturating mismatch count.
- o_match_count  out  CNT_W  saturating match count.
- o_first_err_idx  out  CNT_W  0-based index of the first mismatching sample.
- o_first_err_valid  out  1  o_first_err_idx holds a captured value.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Expected push:** an expected sample is pushed on `i_exp_valid && o_exp_ready`.
  - `o_exp_ready = (o_level != DEPTH)`.
  - There is no pass-through: a push into a full FIFO is refused even if a pop occurs in the same cycle.
- **Actual accept:** an actual sample is accepted on `i_act_valid && o_act_ready`.
  - `o_act_ready = (o_level != 0)`.
  - An expected sample pushed in cycle N is poppable from cycle N+1, never in cycle N.
- **Pop:** an accept pops the FIFO head. A simultaneous push and pop leaves `o_level` unchanged.
- **Compare:**
  - `diff = sext(act) − sext(exp)` at WIDTH+1 bits.
  - The sample matches iff `|diff| ≤ TOL`.
  - `|diff|` of the most negative (WIDTH+1)-bit value is treated as a mismatch.
- **Index counter:** counts accepted samples from 0 and saturates at all-ones.
- **First-error capture:** on the first mismatch, `o_first_err_idx` takes the index and `o_first_err_valid` is set. Later mismatches do not change either.
- **Counter saturation:** `o_err_count` and `o_match_count` saturate at 2^CNT_W−1 and never wrap.
- **i_clear:**
  - Empties the FIFO and zeroes all counters, `o_first_err_*` and the pending compare.
  - It dominates pushes and accepts in the same cycle; both are dropped, but the handshake outputs still reflect the pre-clear state for that cycle.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronously); in-flight compares are discarded and no pulse is produced.

## Timing
- **Reset values:**
  - `o_exp_ready=1`, `o_act_ready=0`, `o_level=0`.
  - `o_err_pulse=0`, all counters 0, `o_first_err_idx=0`, `o_first_err_valid=0`.
- **Compare pipeline:** the compare is registered. An accept in cycle N gives `o_err_pulse` and the counter/first-error updates visible in cycle N+1.
- **Throughput:** back-to-back accepts give back-to-back pulses; throughput is one sample per clock.
- **Handshake outputs:** `o_exp_ready` and `o_act_ready` are combinational functions of `o_level` only, never of the input valids.
- **Level update:** `o_level` updates one cycle after a push or pop.

## Configuration
- **Macro:** `STREAM_ERR_CHECKER_DISPLAY_EN`.
- **Defined:** each mismatch issues one simulation message in the compare-result cycle, giving time, index, actual, expected and diff. The message is enclosed in a synthesis translate-off region.
- **Undefined:** no messages are issued. Logic and port behaviour are identical in both cases.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with level 5.
  - All outputs return to their reset values within the same cycle.
  - No `o_err_pulse` occurs after release.
- **Matching stream:** push 8 expected samples [0, 1, −1, 32767, −32768, 5, 6, 7], then accept the identical 8 actuals back-to-back.
  - `o_match_count=8`, `o_err_count=0`, `o_first_err_valid=0`, no pulses.
- **Mismatch and tolerance:** run TOL=2.
  - Expected [100, 100, 100, 100], actuals [102, 103, 98, 97].
  - Pulses occur on samples 1 and 3 only; `o_err_count=2`, `o_match_count=2`, `o_first_err_idx=1`.
- **Full/empty:** push 16 expected samples with DEPTH=16, then hold `i_exp_valid=1`.
  - `o_exp_ready=0` and the 17th sample is not stored.
  - Drain 16 actuals; `o_act_ready` drops to 0 and the next actual is stalled.
  - Also: push into an empty FIFO with `i_act_valid=1` in the same cycle; the actual is accepted only in the following cycle.
- **Saturation (CNT_W=4):** feed 20 mismatches.
  - `o_err_count` stops at 15 and the index counter stops at 15.
  - `o_first_err_idx` stays 0.
- **Clear:** with level 3 and `o_err_count=2`, assert `i_clear` together with a push and an accept.
  - Next cycle: level 0, counters 0, `o_first_err_valid=0`, no pulse.
